// File: rtl/pi_sequencer.sv
// pi_sequencer: control FSM sequencing the 5x5 lane-permutation datapath from start to done.
// Optional watchdog abort enabled by defining PI_SEQ_WDOG_EN.
module pi_sequencer #(
    parameter int MAX_ITER = 24,
    parameter int ITER_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sign,
    input  logic              dp_done,
    output logic              IJen,
    output logic              IJregen,
    output logic              initLine,
    output logic              read,
    output logic              write,
    output logic              writeVal,
    output logic              writeMemReg,
    output logic              ldTillPositive,
    output logic              waitCalNexti,
    output logic              update,
    output logic              firstread,
    output logic              ok,
    output logic              busy,
    output logic              finish,
    output logic [ITER_W-1:0] iter,
    output logic              err
);
    typedef enum logic [3:0] {IDLE, INIT, SETIJ, RD, CALC, NORM, UPD, WR, FIN} state_t;
    state_t state, state_nxt;
    logic wdog;
`ifdef PI_SEQ_WDOG_EN
    logic [ITER_W:0] iter_inc;
    assign iter_inc = {1'b0, iter} + 1'b1;
    assign wdog = (state == WR) && !dp_done && (iter_inc >= (ITER_W+1)'(MAX_ITER));
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (state == IDLE && start)
            err <= 1'b0;
        else if (wdog)
            err <= 1'b1;
    end
`else
    assign wdog = 1'b0;
    assign err  = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst)
            iter <= '0;
        else if (state == SETIJ)
            iter <= '0;
        else if (state == WR && !(&iter))
            iter <= iter + 1'b1;
    end
    // dp_done is only meaningful after a write; it is also true right after SETIJ.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = start ? INIT : IDLE;
            INIT:       state_nxt = SETIJ;
            SETIJ:      state_nxt = RD;
            RD:         state_nxt = CALC;
            CALC, NORM: state_nxt = sign ? NORM : UPD;
            UPD:        state_nxt = WR;
            WR:         state_nxt = (dp_done || wdog) ? FIN : RD;
            FIN:        state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end
    assign initLine       = state == INIT;
    assign IJen           = state == SETIJ;
    assign IJregen        = state == SETIJ || state == UPD;
    assign read           = state == RD;
    assign writeVal       = state == RD;
    assign writeMemReg    = state == RD;
    assign firstread      = state == RD && iter == '0;
    assign ldTillPositive = state == CALC || state == NORM;
    assign waitCalNexti   = state == NORM;
    assign update         = state == UPD;
    assign write          = state == WR;
    assign ok             = state == FIN;
    assign finish         = state == FIN;
    assign busy           = state != IDLE;
endmodule

// File: tb/tb_pi_sequencer.sv
// tb_pi_sequencer: directed scoreboard bench for pi_sequencer, checking every cycle's controls.
module tb_pi_sequencer;
    localparam int MAX_ITER = 24;
    localparam logic [13:0] IDLE_V = 14'b00000000000000;
    localparam logic [13:0] INIT_V = 14'b00100000000010;
    localparam logic [13:0] SETIJ_V = 14'b11000000000010;
    localparam logic [13:0] RD1_V = 14'b00010110001010;
    localparam logic [13:0] RD_V = 14'b00010110000010;
    localparam logic [13:0] CALC_V = 14'b00000001000010;
    localparam logic [13:0] NORM_V = 14'b00000001100010;
    localparam logic [13:0] UPD_V = 14'b01000000010010;
    localparam logic [13:0] WR_V = 14'b00001000000010;
    localparam logic [13:0] FIN_V = 14'b00000000000111;

    logic clk = 1'b0;
    logic rst, start, sign, dp_done;
    logic IJen, IJregen, initLine, read, write, writeVal, writeMemReg;
    logic ldTillPositive, waitCalNexti, update, firstread, ok, busy, finish;
    logic [4:0] iter;
    logic err;
    logic [13:0] ctl;

    typedef struct packed {
        logic [13:0] ctl;
        logic [4:0]  it;
        logic        er;
    } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0, cyc = 0;
    int c0, c1, sum;
    logic [4:0] exp_iter = '0;
    logic exp_err = 1'b0;
    logic fin;

    always #5 clk = ~clk;

    pi_sequencer #(.MAX_ITER(MAX_ITER), .ITER_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .sign(sign), .dp_done(dp_done),
        .IJen(IJen), .IJregen(IJregen), .initLine(initLine), .read(read),
        .write(write), .writeVal(writeVal), .writeMemReg(writeMemReg),
        .ldTillPositive(ldTillPositive), .waitCalNexti(waitCalNexti),
        .update(update), .firstread(firstread), .ok(ok), .busy(busy),
        .finish(finish), .iter(iter), .err(err)
    );

    assign ctl = {IJen, IJregen, initLine, read, write, writeVal, writeMemReg,
                  ldTillPositive, waitCalNexti, update, firstread, ok, busy, finish};

    task automatic step(input string tag, input logic s_start, input logic s_sign,
                        input logic s_done, input logic [13:0] e_ctl);
        exp_t e;
        start = s_start;
        sign = s_sign;
        dp_done = s_done;
        sb.push_back({e_ctl, exp_iter, exp_err});
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        checks += 3;
        assert (ctl === e.ctl) else begin
            failures++;
            $error("FAIL %s ctl got=%b exp=%b", tag, ctl, e.ctl);
        end
        assert (iter === e.it) else begin
            failures++;
            $error("FAIL %s iter got=%0d exp=%0d", tag, iter, e.it);
        end
        assert (err === e.er) else begin
            failures++;
            $error("FAIL %s err got=%b exp=%b", tag, err, e.er);
        end
    endtask

    // start edge, then INIT, SETIJ (dp_done high there must be ignored), first RD
    task automatic begin_run(input string tag, output int c_start);
        exp_err = 1'b0;
        step(tag, 1'b1, 1'b0, 1'b0, INIT_V);
        c_start = cyc;
        step(tag, 1'b0, 1'b0, 1'b1, SETIJ_V);
        exp_iter = '0;
        step(tag, 1'b0, 1'b0, 1'b1, RD1_V);
    endtask

    // one iteration starting in RD with n NORM cycles; noise toggles ignored inputs
    task automatic iterate(input string tag, input int n, input logic last,
                           input logic noise, output logic f);
        logic wd;
        step(tag, noise, noise, noise, CALC_V);
        if (n == 0) begin
            step(tag, noise, 1'b0, noise, UPD_V);
        end else begin
            for (int k = 0; k < n; k++)
                step(tag, noise, 1'b1, noise, NORM_V);
            step(tag, noise, 1'b0, noise, UPD_V);
        end
        step(tag, noise, noise, noise, WR_V);
        exp_iter = (exp_iter == 5'd31) ? 5'd31 : exp_iter + 5'd1;
`ifdef PI_SEQ_WDOG_EN
        wd = !last && (int'(exp_iter) >= MAX_ITER);
`else
        wd = 1'b0;
`endif
        if (wd)
            exp_err = 1'b1;
        f = last || wd;
        step(tag, 1'b0, 1'b0, last, f ? FIN_V : RD_V);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        sign = 1'b0;
        dp_done = 1'b0;
        step("reset0", 1'b1, 1'b0, 1'b0, IDLE_V);
        step("reset1", 1'b1, 1'b0, 1'b0, IDLE_V);
        rst = 1'b0;
        step("release", 1'b0, 1'b0, 1'b0, IDLE_V);

        begin_run("full_start", c0);
        sum = 0;
        for (int i = 0; i < 24; i++) begin
            int n;
            n = (i == 0) ? 2 : int'($urandom_range(0, 3));
            sum += 4 + n;
            iterate("full", n, i == 23, 1'b0, fin);
        end
        checks++;
        assert (cyc - c0 === 2 + sum) else begin
            failures++;
            $error("FAIL latency got=%0d exp=%0d", cyc - c0, 2 + sum);
        end
        step("fin_hold", 1'b1, 1'b0, 1'b0, IDLE_V);

        begin_run("retrigger", c0);
        for (int i = 0; i < 4; i++) begin
            c1 = cyc;
            iterate("zero_norm", 0, 1'b0, 1'b1, fin);
            checks++;
            assert (cyc - c1 === 4) else begin
                failures++;
                $error("FAIL zero_norm_len got=%0d exp=4", cyc - c1);
            end
        end
        step("it5_calc", 1'b0, 1'b0, 1'b0, CALC_V);
        step("it5_norm", 1'b0, 1'b1, 1'b0, NORM_V);
        rst = 1'b1;
        exp_iter = '0;
        step("mid_rst", 1'b0, 1'b1, 1'b0, IDLE_V);
        rst = 1'b0;
        step("post_rst", 1'b0, 1'b0, 1'b0, IDLE_V);

        begin_run("after_rst", c0);
        iterate("after_rst", 1, 1'b0, 1'b0, fin);
        iterate("after_rst", 3, 1'b1, 1'b0, fin);
        step("after_rst_idle", 1'b0, 1'b0, 1'b0, IDLE_V);

        begin_run("wdog", c0);
        fin = 1'b0;
        for (int i = 0; i < 33 && !fin; i++)
            iterate("wdog", i % 4, 1'b0, 1'b0, fin);
        if (fin) begin
            step("wdog_idle", 1'b0, 1'b0, 1'b0, IDLE_V);
            begin_run("wdog_clear", c0);
        end
        rst = 1'b1;
        exp_iter = '0;
        exp_err = 1'b0;
        step("final_rst", 1'b0, 1'b0, 1'b0, IDLE_V);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pi_sequencer.md
# pi_sequencer

Control FSM that runs the 5×5 lane-permutation datapath (`FDatapath`) from a single `start` pulse to completion.
- Loads the 25-bit line, seeds (i,j)=(3,3), then iterates read → next-index calculation → mod-5 normalisation → index update → write until the datapath reports `done`.
- Sits between the top-level request interface and `FDatapath`. It drives only the datapath's sequencing controls; the top ties `ALUop`, `fb3j`, `fbeq`, `isArith` and `enable` to 0.

## Interface
Parameters:
- `MAX_ITER`, 24: iteration limit used by the watchdog.
- `ITER_W`, 5: width of the iteration counter.

Ports:
- `clk`  in  1  clock. One clock; all state changes on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `start`  in  1  begin a permutation; sampled only in IDLE.
- `sign`  in  1  datapath sign bit of the candidate next-i value (combinational).
- `dp_done`  in  1  datapath `done` (iReg=3, jReg=3).
- `IJen`, `IJregen`, `initLine`, `read`, `write`, `writeVal`, `writeMemReg`, `ldTillPositive`, `waitCalNexti`, `update`, `firstread`, `ok`  out  1 each  datapath controls.
- `busy`  out  1  high in every state except IDLE.
- `finish`  out  1  one-cycle completion pulse.
- `iter`  out  ITER_W  completed iterations.
- `err`  out  1  watchdog abort flag (sticky).

## Operation
- All outputs are Moore-decoded from the state register, except the CALC/NORM exit decision, which uses the live `sign`.
- Every control not listed for a state is 0.

States:
- IDLE: all controls 0.
  - `start` → INIT.
- INIT: `initLine`=1.
  - → SETIJ.
- SETIJ: `IJen`=1, `IJregen`=1; clears `iter`.
  - → RD.
- RD: `read`=1, `writeVal`=1, `writeMemReg`=1; `firstread`=1 only when `iter`=0.
  - → CALC.
- CALC: `ldTillPositive`=1, `waitCalNexti`=0 (loads j−3i).
  - `sign`=1 → NORM; otherwise → UPD.
- NORM: `ldTillPositive`=1, `waitCalNexti`=1 (adds 5 each cycle).
  - `sign`=1 → stay in NORM; `sign`=0 → UPD.
  - Dwell is bounded at 3 cycles, since j−3i ≥ −12.
- UPD: `update`=1, `IJregen`=1.
  - → WR.
- WR: `write`=1; `iter` increments.
  - `dp_done`=1 → FIN; otherwise → RD.
- FIN: `ok`=1, `finish`=1.
  - → IDLE.

Rules:
- `dp_done` is evaluated only in WR. It is also true right after SETIJ and must be ignored there.
- `start` outside IDLE is ignored; there is no queuing.
- `iter` saturates at 2^ITER_W−1.

## Timing
- Reset: state=IDLE; every output 0, `iter`=0, `err`=0.
  - `rst` asserted mid-operation returns to IDLE on the next edge.
  - No write is issued in the cycle after reset.
- `start` sampled high at edge k → INIT during cycle k+1, SETIJ during k+2, first RD during k+3.
- Iteration length is 4+n cycles, where n = number of NORM cycles (0..3).
- Total latency = 2 + Σ(4+nᵢ) + 1 (FIN) cycles after the start edge.
- `finish` and `ok` are high for exactly one cycle.
- `busy` falls in the cycle after FIN.
- `start` held high through FIN re-triggers only after IDLE has been entered; it is sampled in IDLE on the following edge.

## Configuration
- `PI_SEQ_WDOG_EN` defined:
  - In WR with `dp_done`=0 and `iter`+1 ≥ MAX_ITER, the FSM goes to FIN and sets `err`=1.
  - `err` holds until the next accepted `start` or `rst`.
- Undefined:
  - No watchdog logic; `err` is tied to 0.
  - The FSM loops until `dp_done`.

## Test plan
- Reset: hold `rst` 2 cycles with `start`=1 → all outputs 0, state IDLE; `busy` stays 0 in the cycle after release unless `start` is still high.
- First iteration from (3,3): j−3i=−6; drive `sign`=1,1,0 across CALC, NORM, NORM → sequence RD, CALC, NORM, NORM, UPD, WR; `firstread`=1 only in RD; `iter`=1 after WR.
- Full run: datapath model gives `dp_done` after the 24th WR → `finish` pulses once, `iter`=24, `ok`=1 for 1 cycle, `err`=0.
- Zero-NORM path: `sign`=0 in CALC → UPD follows CALC directly; iteration takes 4 cycles.
- Mid-run reset: assert `rst` during NORM of iteration 5 → next cycle IDLE, `iter`=0, `write`=0; a new `start` then runs normally.
- Watchdog (`PI_SEQ_WDOG_EN`, `MAX_ITER`=4): `dp_done` never asserted → FIN after the 4th WR with `err`=1; the next `start` clears `err`. Without the macro, the same stimulus keeps iterating and `err` stays 0.
